// File: rtl/top_k_pkg.sv
// rtl/top_k_pkg.sv - shared constants, header field offsets and FSM state enum for the top-k rx splitter
//
// Purpose : lane geometry, header layout and splitter state encoding.
// Ports   : none (package).
package top_k_pkg;

   localparam int INTEGER_SIZE = 32;   // width of one integer lane / output word
   localparam int LANES        = 16;   // integer lanes per input beat
   localparam int BEAT_W       = 512;  // network-side beat width

   // Header word (lane 0 of a message's first beat)
   localparam int HDR_MASK_LSB = 0;    // [15:0]  enable mask
   localparam int HDR_MASK_W   = 16;
   localparam int HDR_CNT_LSB  = 16;   // [31:16] integer count N
   localparam int HDR_CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } rx_state_e;

endpackage

// File: rtl/top_k_skid_buffer.sv
// rtl/top_k_skid_buffer.sv - 2-entry skid buffer with registered upstream ready
//
// Purpose : decouples the downstream ready from the splitter's output stage
//           while sustaining one word per cycle.
// Ports   : clk, rst            clock, async active-high reset
//           s_tdata_i/s_tvalid_i/s_tready_o   upstream word stream
//           m_tdata_o/m_tvalid_o/m_tready_i   downstream word stream
module top_k_skid_buffer #(
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_tdata_i,
   input  logic             s_tvalid_i,
   output logic             s_tready_o,
   output logic [WIDTH-1:0] m_tdata_o,
   output logic             m_tvalid_o,
   input  logic             m_tready_i
);

   logic [WIDTH-1:0] main_data_q;
   logic [WIDTH-1:0] skid_data_q;
   logic             main_vld_q;
   logic             rdy_q;       // low exactly when the skid entry is occupied

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data_q <= '0;
         skid_data_q <= '0;
         main_vld_q  <= 1'b0;
         rdy_q       <= 1'b1;
      end else if (rdy_q) begin
         if (!main_vld_q || m_tready_i) begin
            main_vld_q <= s_tvalid_i;
            if (s_tvalid_i) main_data_q <= s_tdata_i;
         end else if (s_tvalid_i) begin
            // Downstream stalled while a word was in flight: park it.
            skid_data_q <= s_tdata_i;
            rdy_q       <= 1'b0;
         end
      end else if (m_tready_i) begin
         main_data_q <= skid_data_q;
         main_vld_q  <= 1'b1;
         rdy_q       <= 1'b1;
      end
   end

   assign s_tready_o = rdy_q;
   assign m_tdata_o  = main_data_q;
   assign m_tvalid_o = main_vld_q;

endmodule

// File: rtl/top_k_rx_splitter.sv
// rtl/top_k_rx_splitter.sv - splits 512-bit message beats into a header word plus N integers
//
// Purpose : lane 0 of a message's first beat is the header (mask, count N); the
//           header and then N integers (lane 1 upward, across beats) are emitted
//           one per cycle. Short messages flag err_trunc, long ones are drained
//           and flag err_overrun.
// Config  : TOP_K_RX_SKID_EN inserts top_k_skid_buffer on the m_data port.
// Ports   : clk, rst                        clock, async active-high reset
//           s_axis_TDATA/TVALID/TLAST/TREADY network-side beats
//           m_data_TDATA/TVALID/TLAST/TREADY integer stream to top-k
//           m_clear                          high with the header word only
//           err_trunc, err_overrun           sticky error flags
module top_k_rx_splitter #(
   parameter int INTEGER_SIZE = top_k_pkg::INTEGER_SIZE,
   parameter int LANES        = top_k_pkg::LANES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [top_k_pkg::BEAT_W-1:0]  s_axis_TDATA,
   input  logic                          s_axis_TVALID,
   input  logic                          s_axis_TLAST,
   output logic                          s_axis_TREADY,
   output logic [INTEGER_SIZE-1:0]       m_data_TDATA,
   output logic                          m_data_TVALID,
   output logic                          m_data_TLAST,
   input  logic                          m_data_TREADY,
   output logic                          m_clear,
   output logic                          err_trunc,
   output logic                          err_overrun
);
   import top_k_pkg::*;

   localparam int LANE_W = $clog2(LANES);

   rx_state_e                state_q, state_d;
   logic [LANE_W-1:0]        lane_q, lane_d;
   logic [HDR_CNT_W-1:0]     cnt_q, cnt_d;
   logic                     vld_q, vld_d;
   logic [INTEGER_SIZE-1:0]  data_q, data_d;
   logic                     last_q, last_d;
   logic                     clr_q, clr_d;
   logic                     trunc_q, trunc_d;
   logic                     ovr_q, ovr_d;
   logic                     pop;
   logic                     out_rdy;
   logic                     out_free;

   logic [INTEGER_SIZE-1:0]  lane_word;
   logic [HDR_CNT_W-1:0]     hdr_cnt;
   logic                     lane_last;

   assign lane_word = s_axis_TDATA[int'(lane_q)*INTEGER_SIZE +: INTEGER_SIZE];
   assign hdr_cnt   = s_axis_TDATA[HDR_CNT_LSB +: HDR_CNT_W];
   assign lane_last = (lane_q == LANE_W'(LANES-1));

   // The output register can take a new word when empty or when its word leaves this cycle.
   assign out_free  = !vld_q || out_rdy;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      vld_d   = out_rdy ? 1'b0 : vld_q;
      data_d  = data_q;
      last_d  = last_q;
      clr_d   = clr_q;
      trunc_d = trunc_q;
      ovr_d   = ovr_q;
      pop     = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_axis_TVALID) state_d = HDR;
         end
         HDR: begin
            if (s_axis_TVALID && out_free) begin
               vld_d  = 1'b1;
               data_d = s_axis_TDATA[INTEGER_SIZE-1:0];
               clr_d  = 1'b1;
               cnt_d  = hdr_cnt;
               lane_d = LANE_W'(1);
               if (hdr_cnt == '0) begin
                  last_d  = 1'b1;
                  pop     = 1'b1;
                  state_d = IDLE;
               end else begin
                  last_d  = 1'b0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (s_axis_TVALID && out_free) begin
               vld_d  = 1'b1;
               data_d = lane_word;
               clr_d  = 1'b0;
               last_d = 1'b0;
               lane_d = lane_q + LANE_W'(1);   // wraps to lane 0 together with the beat pop
               if (cnt_q != '0) cnt_d = cnt_q - HDR_CNT_W'(1);
               if (cnt_q == HDR_CNT_W'(1)) begin
                  // Nth integer: remaining lanes of this beat are discarded with the pop.
                  last_d  = 1'b1;
                  pop     = 1'b1;
                  state_d = s_axis_TLAST ? IDLE : DROP;
               end else if (lane_last) begin
                  pop = 1'b1;
                  if (s_axis_TLAST) begin
                     last_d  = 1'b1;
                     trunc_d = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         DROP: begin
            if (s_axis_TVALID && s_axis_TLAST) begin
               ovr_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lane_q  <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         clr_q   <= 1'b0;
         trunc_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         last_q  <= last_d;
         clr_q   <= clr_d;
         trunc_q <= trunc_d;
         ovr_q   <= ovr_d;
      end
   end

   assign s_axis_TREADY = pop || (state_q == DROP);
   assign err_trunc     = trunc_q;
   assign err_overrun   = ovr_q;

`ifdef TOP_K_RX_SKID_EN
   top_k_skid_buffer #(
      .WIDTH (INTEGER_SIZE + 2)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .s_tdata_i  ({clr_q, last_q, data_q}),
      .s_tvalid_i (vld_q),
      .s_tready_o (out_rdy),
      .m_tdata_o  ({m_clear, m_data_TLAST, m_data_TDATA}),
      .m_tvalid_o (m_data_TVALID),
      .m_tready_i (m_data_TREADY)
   );
`else
   assign out_rdy       = m_data_TREADY;
   assign m_data_TDATA  = data_q;
   assign m_data_TVALID = vld_q;
   assign m_data_TLAST  = last_q;
   assign m_clear       = clr_q;
`endif

endmodule

// File: tb/tb_top_k_rx_splitter.sv
// tb/tb_top_k_rx_splitter.sv - scoreboard bench for top_k_rx_splitter
module tb_top_k_rx_splitter;

   logic          clk = 1'b0;
   logic          rst;
   logic [511:0]  s_axis_TDATA;
   logic          s_axis_TVALID;
   logic          s_axis_TLAST;
   logic          s_axis_TREADY;
   logic [31:0]   m_data_TDATA;
   logic          m_data_TVALID;
   logic          m_data_TLAST;
   logic          m_data_TREADY;
   logic          m_clear;
   logic          err_trunc;
   logic          err_overrun;

   int            n_checks = 0;
   int            n_errors = 0;
   int            n_words  = 0;
   int            n_pops   = 0;
   logic [33:0]   exp_q[$];           // {clear, last, data}
   logic          toggle_ready = 1'b0;
   logic          exp_trunc = 1'b0;
   logic          exp_ovr   = 1'b0;
   logic          aborted;
   logic [511:0]  beats[4];

   always #5 clk = ~clk;

   top_k_rx_splitter dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_TDATA  (s_axis_TDATA),
      .s_axis_TVALID (s_axis_TVALID),
      .s_axis_TLAST  (s_axis_TLAST),
      .s_axis_TREADY (s_axis_TREADY),
      .m_data_TDATA  (m_data_TDATA),
      .m_data_TVALID (m_data_TVALID),
      .m_data_TLAST  (m_data_TLAST),
      .m_data_TREADY (m_data_TREADY),
      .m_clear       (m_clear),
      .err_trunc     (err_trunc),
      .err_overrun   (err_overrun)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   initial begin
      m_data_TREADY = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_data_TREADY = toggle_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      logic        hold_vld;
      logic [33:0] hold_word;
      logic [33:0] obs;
      logic [33:0] e;
      hold_vld = 1'b0;
      forever begin
         @(negedge clk);
         obs = {m_clear, m_data_TLAST, m_data_TDATA};
         if (rst) begin
            hold_vld = 1'b0;
         end else begin
            if (hold_vld) chk("stall_hold", 64'({m_data_TVALID, obs}), 64'({1'b1, hold_word}));
            if (s_axis_TVALID && s_axis_TREADY) n_pops++;
            if (m_data_TVALID && m_data_TREADY) begin
               n_words++;
               hold_vld = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("sb_word_available", 64'(exp_q.size()), 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("word", 64'(obs), 64'(e));
               end
            end else begin
               hold_vld  = m_data_TVALID;
               hold_word = obs;
            end
         end
      end
   end

   task automatic fill_msg(input logic [15:0] mask, input int n, input int nb);
      for (int b = 0; b < nb; b++)
         for (int l = 0; l < 16; l++)
            beats[b][32*l +: 32] = $urandom;
      beats[0][31:0] = {n[15:0], mask};
   endtask

   // Reference model: header, then lanes in order until N, TLAST beat exhausted, or N reached early.
   task automatic expect_msg(input int nb);
      logic [31:0] h;
      logic [31:0] w;
      int          n;
      int          emitted;
      bit          done;
      h = beats[0][31:0];
      n = int'(h[31:16]);
      exp_q.push_back({1'b1, (n == 0), h});
      if (n == 0) return;
      emitted = 0;
      done    = 0;
      for (int b = 0; b < nb && !done; b++) begin
         for (int l = (b == 0) ? 1 : 0; l < 16 && !done; l++) begin
            w = beats[b][32*l +: 32];
            emitted++;
            if (emitted == n) begin
               exp_q.push_back({2'b01, w});
               done = 1;
               if (b != nb - 1) exp_ovr = 1'b1;
            end else if (l == 15 && b == nb - 1) begin
               exp_q.push_back({2'b01, w});
               exp_trunc = 1'b1;
               done = 1;
            end else begin
               exp_q.push_back({2'b00, w});
            end
         end
      end
   endtask

   task automatic send_msg(input int nb);
      bit got;
      aborted = 1'b0;
      for (int b = 0; b < nb && !aborted; b++) begin
         s_axis_TDATA  = beats[b];
         s_axis_TLAST  = (b == nb - 1);
         s_axis_TVALID = 1'b1;
         got = 0;
         for (int t = 0; t < 500 && !got && !aborted; t++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
            else if (s_axis_TREADY) got = 1;
            @(posedge clk);
            #1;
         end
         if (!aborted && !got) begin
            chk("beat_pop_timeout", 64'(got), 64'd1);
            aborted = 1'b1;
         end
      end
      s_axis_TVALID = 1'b0;
      s_axis_TLAST  = 1'b0;
      s_axis_TDATA  = '0;
   endtask

   task automatic run_msg(input string name, input int nb, input int exp_words, input logic tog);
      int w0;
      int p0;
      toggle_ready = tog;
      w0 = n_words;
      p0 = n_pops;
      expect_msg(nb);
      send_msg(nb);
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_words"}, 64'(n_words - w0), 64'(exp_words));
      chk({name, "_pops"}, 64'(n_pops - p0), 64'(nb));
      chk({name, "_err_trunc"}, 64'(err_trunc), 64'(exp_trunc));
      chk({name, "_err_overrun"}, 64'(err_overrun), 64'(exp_ovr));
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_m_valid"}, 64'(m_data_TVALID), 64'd0);
      chk({name, "_m_last"}, 64'(m_data_TLAST), 64'd0);
      chk({name, "_m_clear"}, 64'(m_clear), 64'd0);
      chk({name, "_m_data"}, 64'(m_data_TDATA), 64'd0);
      chk({name, "_s_ready"}, 64'(s_axis_TREADY), 64'd0);
      chk({name, "_err_trunc"}, 64'(err_trunc), 64'd0);
      chk({name, "_err_overrun"}, 64'(err_overrun), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      s_axis_TDATA  = '0;
      s_axis_TVALID = 1'b0;
      s_axis_TLAST  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Header 0x0003FFFF with lanes 7, 9, 5 in a single TLAST beat.
      fill_msg(16'hFFFF, 3, 1);
      beats[0][63:32]  = 32'd7;
      beats[0][95:64]  = 32'd9;
      beats[0][127:96] = 32'd5;
      run_msg("n3", 1, 4, 1'b0);

      // N=20 spanning two beats with a stalling consumer.
      fill_msg(16'h00F0, 20, 2);
      run_msg("n20", 2, 21, 1'b1);

      // N=0: header alone carries clear and TLAST.
      fill_msg(16'h1234, 0, 1);
      run_msg("n0", 1, 1, 1'b0);

      // N=40 but message ends after two beats: 31 integers, truncated.
      fill_msg(16'hFFFF, 40, 2);
      run_msg("trunc", 2, 32, 1'b0);

      // N=2 in a three-beat message: remaining beats are dropped.
      fill_msg(16'h0003, 2, 3);
      run_msg("ovr", 3, 3, 1'b0);

      fill_msg(16'hABCD, 5, 1);
      run_msg("after_ovr", 1, 6, 1'b1);

      // Reset in the middle of a DATA phase.
      toggle_ready = 1'b0;
      fill_msg(16'hFFFF, 30, 2);
      expect_msg(2);
      fork
         send_msg(2);
         begin
            repeat (8) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk_all_zero("mid_rst");
         end
      join
      exp_q.delete();
      exp_trunc = 1'b0;
      exp_ovr   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      fill_msg(16'h0F0F, 17, 2);
      run_msg("post_rst", 2, 18, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/top_k_rx_splitter.md
TOP_K_RX_SPLITTER -- requirements
Module: top_k_rx_splitter

Interface
REQ-001 SHALL have parameter INTEGER_SIZE, default 32, width of one integer lane and of the output word.
REQ-002 SHALL have parameter LANES, default 16, number of integer lanes per 512-bit input beat.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have ports s_axis_TDATA  input  512, s_axis_TVALID  input  1, s_axis_TLAST  input  1, s_axis_TREADY  output  1: network-side message stream.
REQ-006 SHALL have ports m_data_TDATA  output  INTEGER_SIZE, m_data_TVALID  output  1, m_data_TLAST  output  1, m_data_TREADY  input  1: integer stream to the top-k block.
REQ-007 SHALL have port m_clear  output  1: high only with the header word, driving the top-k clear input.
REQ-008 SHALL have ports err_trunc  output  1 and err_overrun  output  1: sticky error flags.

Function
REQ-009 SHALL treat lane 0 (bits [31:0]) of a message's first beat as header: [15:0] enable mask, [31:16] integer count N.
REQ-010 SHALL emit the header as the first output word, with m_clear=1, m_data_TDATA = header, m_data_TLAST=0 (N>0).
REQ-011 SHALL emit N integers from lane 1 upward, continuing across beats at lane 0, in lane order; the Nth integer SHALL carry m_data_TLAST=1.
REQ-012 SHALL use FSM states IDLE, HDR, DATA, DROP; IDLE->HDR on s_axis_TVALID; HDR->DATA on header handshake; DATA->IDLE on last-integer handshake; DATA->DROP when N reached but the current beat lacks s_axis_TLAST.
REQ-013 SHALL pulse s_axis_TREADY for one cycle to pop a beat when lane LANES-1 is consumed, when the message ends, or every cycle in DROP.
REQ-014 SHALL keep lanes beyond the Nth integer in the final beat discarded (never emitted).
REQ-015 SHALL, for N=0, emit the header with m_clear=1 and m_data_TLAST=1, pop the beat and return to IDLE.
REQ-016 SHALL, if s_axis_TLAST beat is exhausted before N integers, emit that beat's lane LANES-1 with m_data_TLAST=1, set err_trunc, return to IDLE.
REQ-017 SHALL, in DROP, discard beats up to and including the one with s_axis_TLAST, set err_overrun, return to IDLE.
REQ-018 SHALL hold m_data_TDATA, m_data_TLAST, m_clear stable while m_data_TVALID=1 and m_data_TREADY=0.
REQ-019 SHALL sustain one output word per cycle when m_data_TREADY=1; lane counter 4 bits wraps 15->0 with beat pop.
REQ-020 SHALL count remaining integers in a 16-bit down-counter; no wrap below zero.

Reset
REQ-021 SHALL, on rst, force state IDLE, lane and count counters 0, m_data_TVALID=0, m_data_TLAST=0, m_clear=0, s_axis_TREADY=0, err flags 0, m_data_TDATA=0.
REQ-022 SHALL abandon a message in progress on rst mid-message; the next accepted beat is a header.
REQ-023 SHALL clear err_trunc/err_overrun only by rst.

Configuration
REQ-024 SHALL, with TOP_K_RX_SKID_EN defined, insert a 2-entry skid buffer on the m_data port: +1 cycle latency, registered TREADY path, full throughput.
REQ-025 SHALL, without TOP_K_RX_SKID_EN, drive m_data outputs directly from the lane mux; header appears the cycle after entering HDR.

Structure
REQ-026 SHALL place LANES, INTEGER_SIZE, header field offsets and the FSM state enum in shared package top_k_pkg.
REQ-027 SHALL implement the skid buffer as sub-module top_k_skid_buffer, instantiated only under TOP_K_RX_SKID_EN.

Verification
REQ-028 SHALL cover: header 0x0003_FFFF, lanes 1..3 = 7,9,5, TLAST beat -> words 0x0003FFFF(clear), 7, 9, 5(TLAST); 1 beat popped.
REQ-029 SHALL cover: N=20 over 2 beats, m_data_TREADY toggled 50% -> 21 words in order, data stable during stalls, 2 pops.
REQ-030 SHALL cover: N=0 header -> single word, clear=1, TLAST=1, FSM back to IDLE.
REQ-031 SHALL cover: N=40, TLAST on beat 2 -> 31 integers, 31st with TLAST, err_trunc=1.
REQ-032 SHALL cover: N=2, 3 beats, TLAST on beat 3 -> 3 words, beats 2-3 dropped, err_overrun=1; next message correct.
REQ-033 SHALL cover: rst asserted mid-DATA -> all outputs 0 within same cycle; following header processed normally.
